// File: rtl/axicb_slv_ram.sv
// AXI4 RAM responder for one crossbar slave port: independent write and read burst FSMs.
// Optional macro AXICB_SLV_RAM_ERR_EN: out-of-range beats answer SLVERR instead of wrapping.
module axicb_slv_ram #(
    parameter int AXI_ADDR_W = 16,
    parameter int AXI_ID_W   = 8,
    parameter int AXI_DATA_W = 32,
    parameter int RAM_DEPTH  = 256,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = {AXI_ADDR_W{1'b0}}
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [AXI_ID_W-1:0]     awid,
    input  logic [AXI_ADDR_W-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [AXI_DATA_W-1:0]   wdata,
    input  logic [AXI_DATA_W/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [AXI_ID_W-1:0]     bid,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [AXI_ID_W-1:0]     arid,
    input  logic [AXI_ADDR_W-1:0]   araddr,
    input  logic [7:0]              arlen,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [AXI_ID_W-1:0]     rid,
    output logic [AXI_DATA_W-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast
);
    localparam int STRB_W = AXI_DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(RAM_DEPTH);
`ifdef AXICB_SLV_RAM_ERR_EN
    // The index keeps sign and overflow bits so out-of-range beats stay visible.
    localparam int IW = AXI_ADDR_W + 2;
    function automatic logic [IW-1:0] idx_of(input logic [AXI_ADDR_W-1:0] a);
        logic [IW-1:0] diff;
        diff = {2'b00, a} - {2'b00, BASE_ADDR};
        return IW'($signed(diff) >>> OFF_W);
    endfunction
    function automatic logic oor(input logic [IW-1:0] i);
        return (i[IW-1:IDX_W] != {(IW-IDX_W){1'b0}});
    endfunction
`else
    localparam int IW = IDX_W;
    function automatic logic [IW-1:0] idx_of(input logic [AXI_ADDR_W-1:0] a);
        return IW'((a - BASE_ADDR) >> OFF_W);
    endfunction
`endif
    localparam logic [IW-1:0] IDX_ONE = {{(IW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    logic [AXI_DATA_W-1:0] mem [RAM_DEPTH];

    w_state_e              w_state_q, w_state_d;
    logic [AXI_ID_W-1:0]   wid_q, wid_d;
    logic [IW-1:0]         widx_q, widx_d;
    logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic                  werr_q, werr_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  w_beat_s, w_last_s, mem_we_s;

    r_state_e              r_state_q, r_state_d;
    logic [AXI_ID_W-1:0]   rid_q, rid_d;
    logic [IW-1:0]         ridx_q, ridx_d, rd_idx_s;
    logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rd_load_s;

    // Write FSM next-state; wlast only grades the burst, the beat count ends it.
    always_comb begin
        w_state_d = w_state_q;
        wid_d     = wid_q;
        widx_d    = widx_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        w_beat_s  = 1'b0;
        w_last_s  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    wid_d     = awid;
                    widx_d    = idx_of(awaddr);
                    wlen_d    = awlen;
                    wcnt_d    = 8'd0;
                    werr_d    = 1'b0;
                    w_state_d = W_DATA;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    w_beat_s  = 1'b1;
                    w_last_s  = (wcnt_q == wlen_q);
                    widx_d    = widx_q + IDX_ONE;
                    wcnt_d    = wcnt_q + 8'd1;
`ifdef AXICB_SLV_RAM_ERR_EN
                    werr_d    = werr_q | (wlast != w_last_s) | oor(widx_q);
`else
                    werr_d    = werr_q | (wlast != w_last_s);
`endif
                    w_state_d = w_last_s ? W_RESP : W_DATA;
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (bready && bvalid_q) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
        bresp_d   = ((w_state_d == W_RESP) && werr_d) ? 2'b10 : 2'b00;
    end

`ifdef AXICB_SLV_RAM_ERR_EN
    assign mem_we_s = w_beat_s && aresetn && !oor(widx_q);
`else
    assign mem_we_s = w_beat_s && aresetn;
`endif

    // Read FSM next-state; a RAM word is fetched on the AR handshake and on each non-final R handshake.
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        ridx_d    = ridx_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rlast_d   = rlast_q;
        rd_idx_s  = ridx_q;
        rd_load_s = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    rd_idx_s  = idx_of(araddr);
                    rd_load_s = 1'b1;
                    rid_d     = arid;
                    rlen_d    = arlen;
                    rcnt_d    = 8'd0;
                    rlast_d   = (arlen == 8'd0);
                    r_state_d = R_DATA;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (rready && rvalid_q) begin
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        rd_load_s = 1'b1;
                        rcnt_d    = rcnt_q + 8'd1;
                        rlast_d   = ((rcnt_q + 8'd1) == rlen_q);
                        r_state_d = R_DATA;
                    end
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (rd_load_s) begin
            ridx_d  = rd_idx_s + IDX_ONE;
`ifdef AXICB_SLV_RAM_ERR_EN
            rdata_d = oor(rd_idx_s) ? {AXI_DATA_W{1'b0}} : mem[rd_idx_s[IDX_W-1:0]];
            rresp_d = oor(rd_idx_s) ? 2'b10 : 2'b00;
`else
            rdata_d = mem[rd_idx_s[IDX_W-1:0]];
            rresp_d = 2'b00;
`endif
        end else begin
            rdata_d = rdata_q;
            rresp_d = rresp_q;
        end
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    // RAM write port with byte strobes; contents are not touched by reset.
    always_ff @(posedge aclk) begin
        if (mem_we_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[widx_q[IDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Channel state and registered outputs.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            wid_q     <= {AXI_ID_W{1'b0}};
            widx_q    <= {IW{1'b0}};
            wlen_q    <= 8'd0;
            wcnt_q    <= 8'd0;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            r_state_q <= R_IDLE;
            rid_q     <= {AXI_ID_W{1'b0}};
            ridx_q    <= {IW{1'b0}};
            rlen_q    <= 8'd0;
            rcnt_q    <= 8'd0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= {AXI_DATA_W{1'b0}};
            rresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            wid_q     <= wid_d;
            widx_q    <= widx_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            ridx_q    <= ridx_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = wid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
endmodule
